// File: rtl/framebuffer_scanout_if.sv
// Purpose: bundles the scanout block's generator handshake, framebuffer read port and video output.
// Latency: n/a (signal bundle only).
// Backpressure: none; every signal here is free-running or a single-cycle pulse.
//
// master: the scanout block (drives timing, read address, pixels, frame_start).
// slave : the environment (generator handshake, framebuffer RAM, display sink).
// test_pattern exists only when SCANOUT_TEST_PATTERN_EN is defined.
interface framebuffer_scanout_if #(
    parameter int FRAMEBUFFER_DATA_BITS = 16,
    parameter int FRAMEBUFFER_ADDR_BITS = 14
);
    logic                             frame_done;
    logic                             frame_start;
    logic                             draw_sel;
    logic                             fb_rd_sel;
    logic [FRAMEBUFFER_ADDR_BITS-1:0] fb_rd_addr;
    logic [FRAMEBUFFER_DATA_BITS-1:0] fb_rd_data;
    logic [FRAMEBUFFER_DATA_BITS-1:0] pixel_data;
    logic                             pixel_valid;
    logic                             hsync;
    logic                             vsync;
    logic [15:0]                      frames_shown;
    logic [15:0]                      frames_repeated;
`ifdef SCANOUT_TEST_PATTERN_EN
    logic                             test_pattern;
`endif

    modport master (
`ifdef SCANOUT_TEST_PATTERN_EN
        input  test_pattern,
`endif
        input  frame_done,
        input  fb_rd_data,
        output frame_start,
        output draw_sel,
        output fb_rd_sel,
        output fb_rd_addr,
        output pixel_data,
        output pixel_valid,
        output hsync,
        output vsync,
        output frames_shown,
        output frames_repeated
    );

    modport slave (
`ifdef SCANOUT_TEST_PATTERN_EN
        output test_pattern,
`endif
        output frame_done,
        output fb_rd_data,
        input  frame_start,
        input  draw_sel,
        input  fb_rd_sel,
        input  fb_rd_addr,
        input  pixel_data,
        input  pixel_valid,
        input  hsync,
        input  vsync,
        input  frames_shown,
        input  frames_repeated
    );
endinterface

// File: rtl/framebuffer_scanout.sv
// Purpose: double-buffered framebuffer scanout with raster timing and vblank bank swap.
// Latency: 2 clocks from raster counter position to pixel_data/pixel_valid/hsync/vsync.
// Backpressure: none; timing is free-running, the RAM must return fb_rd_data for the
//               registered fb_rd_addr before the following clock edge.
//
// Ports: clk, rst (synchronous, active-low), bus (framebuffer_scanout_if.master):
//   frame_done in / frame_start out  - generator handshake (one-cycle pulses)
//   draw_sel, fb_rd_sel, fb_rd_addr, fb_rd_data - bank selects and read port
//   pixel_data, pixel_valid, hsync, vsync       - aligned video output
//   frames_shown, frames_repeated               - wrapping vblank statistics
// Optional: define SCANOUT_TEST_PATTERN_EN to add bus.test_pattern (8 vertical colour bars).
module framebuffer_scanout #(
    parameter int DISPLAY_WIDTH         = 100,
    parameter int DISPLAY_HEIGHT        = 100,
    parameter int H_FRONT               = 8,
    parameter int H_SYNC                = 12,
    parameter int H_BACK                = 8,
    parameter int V_FRONT               = 2,
    parameter int V_SYNC                = 2,
    parameter int V_BACK                = 2,
    parameter int SYNC_ACTIVE_LOW       = 1,
    parameter int FRAMEBUFFER_DATA_BITS = 16,
    parameter int FRAMEBUFFER_ADDR_BITS = $clog2(DISPLAY_WIDTH*DISPLAY_HEIGHT)
) (
    input  logic                  clk,
    input  logic                  rst,
    framebuffer_scanout_if.master bus
);
    localparam int H_TOTAL = DISPLAY_WIDTH + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = DISPLAY_HEIGHT + V_FRONT + V_SYNC + V_BACK;
    // One spare code so the sync-window end (which may equal the total) still fits.
    localparam int HW = $clog2(H_TOTAL + 1);
    localparam int VW = $clog2(V_TOTAL + 1);
    localparam int DW = FRAMEBUFFER_DATA_BITS;
    localparam int AW = FRAMEBUFFER_ADDR_BITS;

    localparam logic [HW-1:0] H_ACT      = HW'(DISPLAY_WIDTH);
    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_SYNC_BEG = HW'(DISPLAY_WIDTH + H_FRONT);
    localparam logic [HW-1:0] H_SYNC_END = HW'(DISPLAY_WIDTH + H_FRONT + H_SYNC);
    localparam logic [VW-1:0] V_ACT      = VW'(DISPLAY_HEIGHT);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_SYNC_BEG = VW'(DISPLAY_HEIGHT + V_FRONT);
    localparam logic [VW-1:0] V_SYNC_END = VW'(DISPLAY_HEIGHT + V_FRONT + V_SYNC);

    localparam logic SYNC_ON  = (SYNC_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;
    localparam logic SYNC_OFF = ~SYNC_ON;

    // Raster position
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic [AW-1:0] addr_cnt;

    // Stage 1 (address issued) and stage 2 (data captured)
    logic [AW-1:0] rd_addr_q;
    logic          s1_vld, s1_hs, s1_vs;
    logic [DW-1:0] pix_dat_q;
    logic          pix_vld_q, hs_q, vs_q;

    // Bank swap state
    logic          disp_sel;
    logic          pending;
    logic          frame_start_q;
    logic [15:0]   shown_q;
    logic [15:0]   repeated_q;

    logic active, h_wrap, v_wrap, swap_pt, hs_on, vs_on;

    assign active  = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign h_wrap  = (h_cnt == H_LAST);
    assign v_wrap  = h_wrap && (v_cnt == V_LAST);
    assign swap_pt = (h_cnt == '0) && (v_cnt == V_ACT);
    assign hs_on   = (h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END);
    assign vs_on   = (v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END);

`ifdef SCANOUT_TEST_PATTERN_EN
    logic [2:0] s1_bar;
    logic       s1_tp;

    function automatic logic [DW-1:0] bar_colour(input logic [2:0] idx);
        logic [15:0] c;
        case (idx)
            3'd0:    c = 16'hFFFF;
            3'd1:    c = 16'hFFE0;
            3'd2:    c = 16'h07FF;
            3'd3:    c = 16'h07E0;
            3'd4:    c = 16'hF81F;
            3'd5:    c = 16'hF800;
            3'd6:    c = 16'h001F;
            default: c = 16'h0000;
        endcase
        return DW'(c);
    endfunction

    // Bar index and mode are captured alongside the address so they stay aligned.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_bar <= '0;
            s1_tp  <= 1'b0;
        end else begin
            s1_bar <= 3'((32'(h_cnt) * 8) / DISPLAY_WIDTH);
            s1_tp  <= bus.test_pattern;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_wrap) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    // Linear address walks with the raster: steps on active pixels only, so it
    // naturally holds across horizontal blank and lands on x + W*y without a multiply.
    always_ff @(posedge clk) begin
        if (!rst || v_wrap) begin
            addr_cnt <= '0;
        end else if (active) begin
            addr_cnt <= addr_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_addr_q <= '0;
            s1_vld    <= 1'b0;
            s1_hs     <= SYNC_OFF;
            s1_vs     <= SYNC_OFF;
            pix_dat_q <= '0;
            pix_vld_q <= 1'b0;
            hs_q      <= SYNC_OFF;
            vs_q      <= SYNC_OFF;
        end else begin
            rd_addr_q <= addr_cnt;
            s1_vld    <= active;
            s1_hs     <= hs_on ? SYNC_ON : SYNC_OFF;
            s1_vs     <= vs_on ? SYNC_ON : SYNC_OFF;
            pix_vld_q <= s1_vld;
            hs_q      <= s1_hs;
            vs_q      <= s1_vs;
            if (!s1_vld) begin
                pix_dat_q <= '0;
`ifdef SCANOUT_TEST_PATTERN_EN
            end else if (s1_tp) begin
                pix_dat_q <= bar_colour(s1_bar);
`endif
            end else begin
                pix_dat_q <= bus.fb_rd_data;
            end
        end
    end

    // Swap only on the first vblank cycle, so the read bank never changes mid-frame.
    // A frame_done landing exactly on the swap cycle counts as already pending.
    always_ff @(posedge clk) begin
        if (!rst) begin
            disp_sel      <= 1'b0;
            pending       <= 1'b1;
            frame_start_q <= 1'b0;
            shown_q       <= '0;
            repeated_q    <= '0;
        end else begin
            frame_start_q <= 1'b0;
            if (swap_pt) begin
                if (pending || bus.frame_done) begin
                    disp_sel      <= ~disp_sel;
                    pending       <= 1'b0;
                    frame_start_q <= 1'b1;
                    shown_q       <= shown_q + 1'b1;
                end else begin
                    repeated_q    <= repeated_q + 1'b1;
                end
            end else if (bus.frame_done) begin
                pending <= 1'b1;
            end
        end
    end

    assign bus.frame_start     = frame_start_q;
    assign bus.draw_sel        = ~disp_sel;
    assign bus.fb_rd_sel       = disp_sel;
    assign bus.fb_rd_addr      = rd_addr_q;
    assign bus.pixel_data      = pix_dat_q;
    assign bus.pixel_valid     = pix_vld_q;
    assign bus.hsync           = hs_q;
    assign bus.vsync           = vs_q;
    assign bus.frames_shown    = shown_q;
    assign bus.frames_repeated = repeated_q;
endmodule

// File: tb/tb_framebuffer_scanout.sv
// Purpose: randomized scoreboard bench for framebuffer_scanout (8x4 display, all porches 1).
// Latency: expects outputs 2 clocks after each raster position, frame_start 1 clock after swap.
// Backpressure: none; the RAM model answers combinationally from the registered address.
module tb_framebuffer_scanout;
    localparam int W  = 8;
    localparam int H  = 4;
    localparam int HT = 11;
    localparam int VT = 7;
    localparam int FT = HT * VT;
    localparam int AB = 5;
    localparam int DB = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    framebuffer_scanout_if #(.FRAMEBUFFER_DATA_BITS(DB), .FRAMEBUFFER_ADDR_BITS(AB)) bus();

    framebuffer_scanout #(
        .DISPLAY_WIDTH(W), .DISPLAY_HEIGHT(H),
        .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
        .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .SYNC_ACTIVE_LOW(1),
        .FRAMEBUFFER_DATA_BITS(DB), .FRAMEBUFFER_ADDR_BITS(AB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    // Two-bank framebuffer RAM
    logic [DB-1:0] mem [2][32];
    assign bus.fb_rd_data = mem[bus.fb_rd_sel][bus.fb_rd_addr];
`ifdef SCANOUT_TEST_PATTERN_EN
    assign bus.test_pattern = 1'b0;
`endif

    typedef struct { int cyc; logic [DB-1:0] dat; } pix_t;
    typedef struct { int cyc; logic vld; logic hs; logic vs; } out_t;
    pix_t pq[$];
    out_t oq[$];
    int   fsq[$];

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int t0         = 0;
    bit cnt_en     = 1'b0;
    int n_vld = 0, n_hs = 0, n_vs = 0;

    // Reference state for the swap rules
    bit m_bank;
    bit m_pend;
    int m_shown;
    int m_rep;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_bank  = 1'b0;
        m_pend  = 1'b1;
        m_shown = 0;
        m_rep   = 0;
    endtask

    // One clock of stimulus; the expected outputs for this raster position are queued.
    task automatic step(input bit fd, input bit rs);
        int t, x, y;
        t = cyc - t0;
        x = t % HT;
        y = (t / HT) % VT;
        if (!rs && t % FT == FT - 1) begin
            check("frames_shown", 32'(bus.frames_shown), 32'(16'(m_shown)));
            check("frames_repeated", 32'(bus.frames_repeated), 32'(16'(m_rep)));
            check("fb_rd_sel", 32'(bus.fb_rd_sel), 32'(m_bank));
            check("draw_sel", 32'(bus.draw_sel), 32'(!m_bank));
        end
        bus.frame_done = fd;
        rst = rs ? 1'b0 : 1'b1;
        if (!rs) begin
            if (x < W && y < H) pq.push_back('{cyc + 2, mem[m_bank][x + W * y]});
            oq.push_back('{cyc + 2, (x < W && y < H), (x == W + 1), (y == H + 1)});
            if (x == 0 && y == H) begin
                if (m_pend || fd) begin
                    m_bank = !m_bank;
                    m_pend = 1'b0;
                    m_shown++;
                    fsq.push_back(cyc + 1);
                    for (int a = 0; a < 32; a++) mem[!m_bank][a] = DB'($urandom);
                end else begin
                    m_rep++;
                end
            end else if (fd) begin
                m_pend = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (rs) begin
            pq.delete();
            oq.delete();
            fsq.delete();
            model_reset();
            t0 = cyc;
            check("rst_frame_start", 32'(bus.frame_start), 32'd0);
            check("rst_pixel_data", 32'(bus.pixel_data), 32'd0);
            check("rst_pixel_valid", 32'(bus.pixel_valid), 32'd0);
            check("rst_hsync", 32'(bus.hsync), 32'd1);
            check("rst_vsync", 32'(bus.vsync), 32'd1);
            check("rst_fb_rd_addr", 32'(bus.fb_rd_addr), 32'd0);
            check("rst_fb_rd_sel", 32'(bus.fb_rd_sel), 32'd0);
            check("rst_frames_shown", 32'(bus.frames_shown), 32'd0);
            check("rst_frames_repeated", 32'(bus.frames_repeated), 32'd0);
        end
    endtask

    // Monitor: compares whatever the DUT presents against the queued expectations.
    always @(negedge clk) begin
        int rel;
        rel = cyc - t0;
        if (cnt_en && rel >= 2 && rel <= FT + 1) begin
            n_vld += int'(bus.pixel_valid === 1'b1);
            n_hs  += int'(bus.hsync === 1'b0);
            n_vs  += int'(bus.vsync === 1'b0);
        end
        if (oq.size() > 0 && oq[0].cyc == cyc) begin
            out_t o;
            o = oq.pop_front();
            check("pixel_valid", 32'(bus.pixel_valid), 32'(o.vld));
            check("hsync", 32'(bus.hsync), 32'(!o.hs));
            check("vsync", 32'(bus.vsync), 32'(!o.vs));
            if (!o.vld) check("blank_data", 32'(bus.pixel_data), 32'd0);
        end
        if (bus.pixel_valid === 1'b1) begin
            if (pq.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL pixel_unexpected @cyc %0d: got data %0h, expected no pixel", cyc, bus.pixel_data);
            end else begin
                pix_t p;
                p = pq.pop_front();
                check("pixel_cycle", 32'(cyc), 32'(p.cyc));
                check("pixel_data", 32'(bus.pixel_data), 32'(p.dat));
            end
        end
        if (bus.frame_start === 1'b1) begin
            if (fsq.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL frame_start_unexpected @cyc %0d: got pulse, expected none", cyc);
            end else begin
                check("frame_start_cycle", 32'(cyc), 32'(fsq.pop_front()));
            end
        end
    end

    initial begin
        bus.frame_done = 1'b0;
        for (int a = 0; a < 32; a++) begin
            mem[0][a] = DB'(a);
            mem[1][a] = DB'($urandom);
        end
        model_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1);

        // Frames 0 and 1: no frame_done -> bootstrap swap, then a repeat.
        cnt_en = 1'b1;
        for (int c = 0; c < 2 * FT; c++) step(1'b0, 1'b0);
        cnt_en = 1'b0;
        check("valid_count", 32'(n_vld), 32'd32);
        check("hsync_count", 32'(n_hs), 32'd7);
        check("vsync_count", 32'(n_vs), 32'd11);

        // Frame 2: frame_done exactly on the swap-point cycle.
        for (int c = 0; c < FT; c++) step(c == W * 0 + HT * H, 1'b0);
        // Frame 3: two frame_done pulses before vblank; frame 4: none (must repeat).
        for (int c = 0; c < FT; c++) step(c == 5 || c == 20, 1'b0);
        for (int c = 0; c < FT; c++) step(1'b0, 1'b0);
        // Frames 5..9: random generator completions.
        for (int c = 0; c < 5 * FT; c++) step($urandom_range(0, 29) == 0, 1'b0);
        // Frame 10: reset at h_cnt=3, v_cnt=2, then two frames of random traffic.
        for (int c = 0; c < 2 * HT + 3; c++) step($urandom_range(0, 29) == 0, 1'b0);
        step(1'b0, 1'b1);
        for (int c = 0; c < 2 * FT - 5; c++) step($urandom_range(0, 19) == 0, 1'b0);

        @(negedge clk);
        check("pixel_queue_drained", 32'(pq.size()), 32'd0);
        check("frame_start_queue_drained", 32'(fsq.size()), 32'd0);
        check("final_frames_shown", 32'(bus.frames_shown), 32'(16'(m_shown)));
        check("final_frames_repeated", 32'(bus.frames_repeated), 32'(16'(m_rep)));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/framebuffer_scanout.md
Name: framebuffer_scanout

Overview:
- Downstream consumer of the video generator's framebuffer output.
- Owns two framebuffer banks, scans the display bank out as a timed pixel stream, and swaps banks at vertical blank.
- Produces the generator's frame_start pulse and consumes its frame_done pulse, so that drawing always targets the hidden bank.

Parameters:
- DISPLAY_WIDTH, 100, active pixels per line
- DISPLAY_HEIGHT, 100, active lines per frame
- H_FRONT, 8, horizontal front porch (clocks)
- H_SYNC, 12, horizontal sync width
- H_BACK, 8, horizontal back porch
- V_FRONT, 2, vertical front porch (lines)
- V_SYNC, 2, vertical sync width
- V_BACK, 2, vertical back porch
- SYNC_ACTIVE_LOW, 1, 1 = hsync/vsync asserted low
- FRAMEBUFFER_DATA_BITS, 16, pixel colour width
- FRAMEBUFFER_ADDR_BITS, $clog2(DISPLAY_WIDTH*DISPLAY_HEIGHT), bank address width

Ports:
- clk  in  1  system clock; all logic on posedge
- rst  in  1  synchronous reset, active-low
- frame_done  in  1  one-cycle pulse from generator: hidden bank complete
- frame_start  out  1  one-cycle pulse to generator: begin drawing hidden bank
- draw_sel  out  1  bank the generator writes (always ~disp_sel)
- fb_rd_sel  out  1  bank being read (disp_sel)
- fb_rd_addr  out  FRAMEBUFFER_ADDR_BITS  read address, x + DISPLAY_WIDTH*y
- fb_rd_data  in  FRAMEBUFFER_DATA_BITS  RAM data, valid one cycle after fb_rd_addr
- pixel_data  out  FRAMEBUFFER_DATA_BITS  output colour; 0 when blanked
- pixel_valid  out  1  active-region pixel
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- frames_shown  out  16  count of completed bank swaps (wraps)
- frames_repeated  out  16  vblanks without a swap (wraps)

Behaviour:
- Timing constants: H_TOTAL = DISPLAY_WIDTH + H_FRONT + H_SYNC + H_BACK. V_TOTAL is defined likewise.
- Counters: h_cnt runs 0..H_TOTAL-1. At wrap, h_cnt goes to 0 and v_cnt increments. v_cnt wraps V_TOTAL-1 -> 0.
- Active region: h_cnt < DISPLAY_WIDTH && v_cnt < DISPLAY_HEIGHT.
- Sync windows:
  - hsync asserted for h_cnt in [DISPLAY_WIDTH+H_FRONT, DISPLAY_WIDTH+H_FRONT+H_SYNC).
  - vsync asserted for v_cnt in the same window pattern.
  - Polarity is set by SYNC_ACTIVE_LOW.
- Pipeline, cycle N is the counter position:
  - N+1: fb_rd_addr registered; address is don't-care outside the active region.
  - N+2: fb_rd_data captured into pixel_data.
  - pixel_valid, hsync and vsync are delayed through the same 2 stages, so all outputs align. Fixed latency is 2 clocks.
  - pixel_data = 0 whenever its aligned pixel_valid = 0.
- Address is computed incrementally, with no multiplier on the read path:
  - Increments in the active region.
  - Holds during horizontal blank.
  - Resets to 0 at v_cnt wrap.
- Swap control:
  - pending flag is set by frame_done.
  - Swap point: the cycle where h_cnt==0 && v_cnt==DISPLAY_HEIGHT (first vblank cycle).
  - At the swap point with pending (or frame_done in that same cycle): disp_sel toggles, pending clears, frame_start pulses 1 cycle (the next cycle), frames_shown++.
  - At the swap point without pending: no toggle, no frame_start, frames_repeated++. The display bank is shown again.
  - frame_done while pending=1: no additional effect.
  - frame_done at any non-swap cycle: only sets pending.
- fb_rd_sel changes only at the swap point. It is therefore never mid-active-frame, so there is no tearing.
- Reset (rst==0) values:
  - h_cnt=v_cnt=0, disp_sel=0, pending=1 (bootstraps the first frame_start at the first vblank).
  - frame_start=0, pixel_data=0, pixel_valid=0, hsync=vsync=inactive level, fb_rd_addr=0.
  - frames_shown=frames_repeated=0.
- Reset mid-frame: all state returns to the reset values on the next edge. The pipeline is flushed (valid=0).

Optional Feature:
- Macro: SCANOUT_TEST_PATTERN_EN.
- When defined, the block adds input test_pattern (1 bit).
  - When test_pattern==1, pixel_data ignores fb_rd_data and carries 8 vertical colour bars: bar index = x*8/DISPLAY_WIDTH, colours {0xFFFF,0xFFE0,0x07FF,0x07E0,0xF81F,0xF800,0x001F,0x0000}.
  - Latency, sync and swap behaviour are unchanged.
- When undefined, the port and its logic are absent.

Test Plan:
- Bench configuration: DISPLAY_WIDTH=8, DISPLAY_HEIGHT=4, porches/syncs all 1 (H_TOTAL=11, V_TOTAL=7).
- Timing: release rst, run 77 clocks -> exactly 32 pixel_valid cycles; hsync asserted 1 clock per line (7 per frame); vsync asserted 11 clocks.
- Latency/addressing: RAM model returns addr as data -> pixel_data sequence 0..31 in order, each 2 clocks after its counter position, aligned with pixel_valid.
- Bootstrap: no frame_done after reset -> frame_start pulses once at the first vblank (cycle 44+1); disp_sel=1, frames_shown=1.
- Repeat: no frame_done during the next frame -> no frame_start at the second vblank; frames_repeated=1; fb_rd_sel stays 1.
- Simultaneous: frame_done asserted exactly at a swap-point cycle -> swap occurs that vblank, frame_start next cycle. A second frame_done before that vblank has no extra effect.
- Reset mid-frame: rst low at h_cnt=3, v_cnt=2 -> next cycle all outputs at reset values; after release, pixel output restarts from address 0.
